// File: rtl/ram_loader.sv
// ram_loader: boot-time program loader.
// Receives a little-endian byte stream (16-bit word count, then 4*N data
// bytes) over valid/ready and writes it as whole 32-bit words into the
// RAM write port, holding the core in reset until the image is complete.
module ram_loader #(
  parameter int ADDR_W    = 14,
  parameter int BASE_WORD = 0
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic        start,
  output logic [31:2] ram_addr,
  output logic [3:0]  ram_wstrb,
  output logic [31:0] ram_wdata,
  output logic        core_hold,
  output logic        done
);

  // Only the implemented address bits of the base take part in addressing.
  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_WORD);

  typedef enum logic [2:0] {
    S_LEN_LO = 3'd0,
    S_LEN_HI = 3'd1,
    S_DATA   = 3'd2,
    S_WRITE  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t              state_q;
  logic [15:0]         count_q;
  logic [1:0]          lane_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         wdata_q;

  // Place one stream byte into its little-endian lane of the word.
  function automatic logic [31:0] put_lane(input logic [31:0] word,
                                           input logic [1:0]  lane,
                                           input logic [7:0]  b);
    logic [31:0] r;
    r = word;
    case (lane)
      2'd0:    r[7:0]   = b;
      2'd1:    r[15:8]  = b;
      2'd2:    r[23:16] = b;
      default: r[31:24] = b;
    endcase
    return r;
  endfunction

  // Next word address; wraps naturally modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return a + ADDR_W'(1);
  endfunction

  // Control FSM: length capture, byte-lane assembly, write issue, completion.
  always_ff @(posedge clk or posedge resetb) begin
    if (resetb) begin
      state_q <= S_LEN_LO;
      count_q <= '0;
      lane_q  <= '0;
    end else begin
      unique case (state_q)
        S_LEN_LO: begin
          if (in_valid) begin
            count_q[7:0] <= in_data;
            state_q      <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (in_valid) begin
            count_q[15:8] <= in_data;
            lane_q        <= 2'd0;
            // An empty image finishes immediately without touching the RAM.
            if ({in_data, count_q[7:0]} == 16'd0) begin
              state_q <= S_DONE;
            end else begin
              state_q <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (in_valid) begin
            lane_q <= lane_q + 2'd1;
            if (lane_q == 2'd3) begin
              state_q <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          count_q <= count_q - 16'd1;
          lane_q  <= 2'd0;
          if (count_q == 16'd1) begin
            state_q <= S_DONE;
          end else begin
            state_q <= S_DATA;
          end
        end
        S_DONE: begin
          // A new load is only accepted once the previous one has finished.
          if (start) begin
            state_q <= S_LEN_LO;
          end
        end
        default: begin
          state_q <= S_LEN_LO;
        end
      endcase
    end
  end

  // Write datapath: assemble data bytes and step the word address per write.
  always_ff @(posedge clk or posedge resetb) begin
    if (resetb) begin
      addr_q  <= BASE_A;
      wdata_q <= '0;
    end else begin
      if (state_q == S_DATA && in_valid) begin
        wdata_q <= put_lane(wdata_q, lane_q, in_data);
      end
      if (state_q == S_WRITE) begin
        addr_q <= next_addr(addr_q);
      end else if (state_q == S_DONE && start) begin
        addr_q <= BASE_A;
      end
    end
  end

  // Handshake and status outputs depend on the state register alone.
  assign in_ready  = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                     (state_q == S_DATA);
  assign ram_wstrb = {4{state_q == S_WRITE}};
  assign done      = (state_q == S_DONE);
  assign core_hold = (state_q != S_DONE);
  assign ram_addr  = 30'(addr_q);
  assign ram_wdata = wdata_q;

endmodule

// File: tb/tb_ram_loader.sv
// Bench for ram_loader: two instances (wide address space at base 0x10, and a
// 4-word space at base 3 so addresses wrap) see identical byte streams. The
// expected write list is computed directly from the stream's word list.
module tb_ram_loader;

  localparam int A_W = 14;
  localparam int A_BASE = 32'h10;
  localparam int B_W = 2;
  localparam int B_BASE = 3;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        start;

  logic        in_ready_a, core_hold_a, done_a;
  logic [31:2] ram_addr_a;
  logic [3:0]  ram_wstrb_a;
  logic [31:0] ram_wdata_a;
  logic        in_ready_b, core_hold_b, done_b;
  logic [31:2] ram_addr_b;
  logic [3:0]  ram_wstrb_b;
  logic [31:0] ram_wdata_b;

  ram_loader #(.ADDR_W(A_W), .BASE_WORD(A_BASE)) dut_a (
    .clk(clk), .resetb(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_a), .start(start), .ram_addr(ram_addr_a),
    .ram_wstrb(ram_wstrb_a), .ram_wdata(ram_wdata_a),
    .core_hold(core_hold_a), .done(done_a)
  );

  ram_loader #(.ADDR_W(B_W), .BASE_WORD(B_BASE)) dut_b (
    .clk(clk), .resetb(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_b), .start(start), .ram_addr(ram_addr_b),
    .ram_wstrb(ram_wstrb_b), .ram_wdata(ram_wdata_b),
    .core_hold(core_hold_b), .done(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [29:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_a[$];
  wr_t         exp_b[$];
  logic [31:0] words[$];
  logic [7:0]  stream[$];

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int nbytes = 0;
  int nwr_a = 0, nwr_b = 0;
  int last_wr_a = 0, last_wr_b = 0;
  int done_rise_a = 0, done_rise_b = 0;
  logic done_q_a = 1'b0, done_q_b = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Accepted bytes, counted at the transfer edge.
  always @(posedge clk) begin
    if (!rst && in_valid && in_ready_a) nbytes <= nbytes + 1;
  end

  // Write monitor: every strobe must match the next expected write.
  always @(negedge clk) begin
    if (!rst) begin
      cyc <= cyc + 1;
      done_q_a <= done_a;
      done_q_b <= done_b;
      if (done_a && !done_q_a) done_rise_a <= cyc;
      if (done_b && !done_q_b) done_rise_b <= cyc;
      if (ram_wstrb_a != 4'h0) begin
        check("a_strb", ram_wstrb_a, 4'hF);
        check("a_hold_wr", core_hold_a, 1);
        check("a_wr_avail", exp_a.size() > 0, 1);
        if (exp_a.size() > 0) begin
          check("a_addr", ram_addr_a, exp_a[0].addr);
          check("a_data", ram_wdata_a, exp_a[0].data);
          void'(exp_a.pop_front());
        end
        nwr_a <= nwr_a + 1;
        last_wr_a <= cyc;
      end
      if (ram_wstrb_b != 4'h0) begin
        check("b_strb", ram_wstrb_b, 4'hF);
        check("b_hold_wr", core_hold_b, 1);
        check("b_wr_avail", exp_b.size() > 0, 1);
        if (exp_b.size() > 0) begin
          check("b_addr", ram_addr_b, exp_b[0].addr);
          check("b_data", ram_wdata_b, exp_b[0].data);
          void'(exp_b.pop_front());
        end
        nwr_b <= nwr_b + 1;
        last_wr_b <= cyc;
      end
    end
  end

  // Reference: stream = count LE, words LSB first; word i lands at base+i mod 2^W.
  task automatic build(input bit push_exp);
    int  n;
    wr_t e;
    n = words.size();
    stream = {};
    stream.push_back(8'(n));
    stream.push_back(8'(n >> 8));
    for (int i = 0; i < n; i++) begin
      for (int b = 0; b < 4; b++) stream.push_back(8'(words[i] >> (8 * b)));
      if (push_exp) begin
        e.addr = 30'((A_BASE + i) % (1 << A_W));
        e.data = words[i];
        exp_a.push_back(e);
        e.addr = 30'((B_BASE + i) % (1 << B_W));
        exp_b.push_back(e);
      end
    end
  endtask

  task automatic send_stream(input int max_gap, input int stop_after, input int start_at);
    int waited;
    for (int i = 0; i < stream.size(); i++) begin
      if (stop_after >= 0 && i == stop_after) break;
      @(negedge clk);
      start = 1'b0;
      // Idle gaps only while the loader is ready; valid stays high across WRITE.
      if (max_gap > 0 && i > 0 && in_ready_a) begin
        in_valid = 1'b0;
        in_data = 8'($urandom);
        repeat ($urandom_range(1, max_gap)) @(negedge clk);
      end
      in_valid = 1'b1;
      in_data = stream[i];
      if (i == start_at) start = 1'b1;
      waited = 0;
      while (!in_ready_a && waited < 50) begin
        @(negedge clk);
        waited++;
      end
      if (!in_ready_a) begin
        check("ready_timeout", in_ready_a, 1);
        in_valid = 1'b0;
        start = 1'b0;
        return;
      end
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (!(done_a && done_b) && k < 400) begin
      @(negedge clk);
      k++;
    end
    #1;
    check("done_timeout", done_a && done_b, 1);
  endtask

  task automatic run_load(input int gap, input int start_at);
    int n, nb0, wa0, wb0;
    n = words.size();
    build(1'b1);
    nb0 = nbytes;
    wa0 = nwr_a;
    wb0 = nwr_b;
    send_stream(gap, -1, start_at);
    if (n == 0) begin
      #1;
      check("zero_done_a", done_a, 1);
      check("zero_done_b", done_b, 1);
      check("zero_hold_a", core_hold_a, 0);
    end else begin
      wait_done();
      check("done_lag_a", done_rise_a - last_wr_a, 1);
      check("done_lag_b", done_rise_b - last_wr_b, 1);
      check("end_hold_a", core_hold_a, 0);
      check("end_hold_b", core_hold_b, 0);
    end
    check("bytes", nbytes - nb0, 2 + 4 * n);
    check("wr_cnt_a", nwr_a - wa0, n);
    check("wr_cnt_b", nwr_b - wb0, n);
    check("pend_a", exp_a.size(), 0);
    check("pend_b", exp_b.size(), 0);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    check("start_hold_a", core_hold_a, 1);
    check("start_hold_b", core_hold_b, 1);
    check("start_done_a", done_a, 0);
    check("start_rdy_a", in_ready_a, 1);
  endtask

  task automatic reset_vals();
    check("rst_rdy_a", in_ready_a, 1);
    check("rst_strb_a", ram_wstrb_a, 0);
    check("rst_addr_a", ram_addr_a, A_BASE);
    check("rst_wdata_a", ram_wdata_a, 0);
    check("rst_hold_a", core_hold_a, 1);
    check("rst_done_a", done_a, 0);
    check("rst_strb_b", ram_wstrb_b, 0);
    check("rst_addr_b", ram_addr_b, B_BASE);
    check("rst_wdata_b", ram_wdata_b, 0);
    check("rst_hold_b", core_hold_b, 1);
  endtask

  // Reset raised between clock edges and observed before the next edge.
  task automatic async_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1 reset_vals();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, wa0, wb0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    start = 1'b0;
    repeat (2) @(negedge clk);
    #1 reset_vals();
    @(negedge clk);
    rst = 1'b0;

    // Two-word load, continuous source.
    words = {32'hDEADBEEF, 32'h12345678};
    run_load(0, -1);

    // Zero count.
    pulse_start();
    words = {};
    run_load(0, -1);

    // Same image with idle gaps between bytes.
    pulse_start();
    words = {32'hDEADBEEF, 32'h12345678};
    run_load(3, -1);

    // Wrap image (wraps on the 4-word instance).
    pulse_start();
    words = {32'h11111111, 32'h22222222};
    run_load(0, -1);

    // Reset while finished: address returns to base.
    async_reset();

    // Reset mid-word: no strobe, then a fresh image loads from base.
    words = {32'hDEADBEEF, 32'h12345678};
    build(1'b0);
    wa0 = nwr_a;
    wb0 = nwr_b;
    send_stream(0, 4, -1);
    async_reset();
    check("abort_wr_a", nwr_a - wa0, 0);
    check("abort_wr_b", nwr_b - wb0, 0);
    run_load(2, -1);

    // Restart, with stray start pulses in LEN_LO and mid-data.
    pulse_start();
    pulse_start();
    words = {32'h11223344};
    run_load(0, 3);

    // Random images.
    for (int r = 0; r < 4; r++) begin
      pulse_start();
      words = {};
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) words.push_back($urandom);
      run_load($urandom_range(0, 2), $urandom_range(2, 1 + 4 * n));
    end

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
